// File: rtl/phy_clk_enable_gen_if.sv
// Control/status bundle between phy_clk_enable_gen and its PLL/PHY-datapath neighbours.
`timescale 1ns/1ps
interface phy_clk_enable_gen_if #(
  parameter int unsigned NUM_CH = 3
);
  logic              pll_locked;
  logic [NUM_CH-1:0] ch_en;
  logic              sync_i;
  logic [NUM_CH-1:0] ce;
  logic [NUM_CH-1:0] clk_div;
  logic [NUM_CH-1:0] active;
  logic              locked;

  modport master (
    output pll_locked, ch_en, sync_i,
    input  ce, clk_div, active, locked
  );

  modport slave (
    input  pll_locked, ch_en, sync_i,
    output ce, clk_div, active, locked
  );
endinterface

// File: rtl/phy_clk_enable_gen.sv
// Lock-qualified per-channel clock-enable / divided-clock generator for the PHY datapath.
// Optional counter realignment on sync_i is built only with PHY_CLK_PHASE_ALIGN_EN defined.
`timescale 1ns/1ps
module phy_clk_enable_gen #(
  parameter int unsigned NUM_CH      = 3,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned DIV0        = 5,
  parameter int unsigned DIV1        = 10,
  parameter int unsigned DIV2        = 50,
  parameter int unsigned DIVN        = 2,
  parameter int unsigned LOCK_CYCLES = 1024,
  parameter int unsigned LOCK_W      = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  phy_clk_enable_gen_if.slave  bus
);

  typedef enum logic [1:0] {
    CH_OFF   = 2'd0,
    CH_RUN   = 2'd1,
    CH_DRAIN = 2'd2
  } ch_state_e;

  function automatic int unsigned div_of(int unsigned ch);
    case (ch)
      0:       return DIV0;
      1:       return DIV1;
      2:       return DIV2;
      default: return DIVN;
    endcase
  endfunction

  localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_CYCLES - 1);

  logic              pll_m_q, pll_s_q;
  logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
  logic              locked_q, locked_d;

  always_comb begin
    lock_cnt_d = lock_cnt_q;
    if (!pll_s_q) begin
      lock_cnt_d = '0;
    end else if (lock_cnt_q != LOCK_MAX) begin
      lock_cnt_d = lock_cnt_q + LOCK_W'(1);
    end
    locked_d = pll_s_q && (lock_cnt_q == LOCK_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pll_m_q    <= 1'b0;
      pll_s_q    <= 1'b0;
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
    end else begin
      pll_m_q    <= bus.pll_locked;
      pll_s_q    <= pll_m_q;
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
    end
  end

  assign bus.locked = locked_q;

  logic [NUM_CH-1:0] ce_w, clk_div_w, active_w;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    localparam int unsigned DIV = div_of(g);

    if (DIV == 0) begin : g_div_zero
      $error("phy_clk_enable_gen: channel divisor must be non-zero");
    end
    if (DIV >= (2 ** CNT_W)) begin : g_div_wide
      $error("phy_clk_enable_gen: channel divisor does not fit CNT_W");
    end

    localparam logic [CNT_W-1:0] TC   = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(DIV / 2);

    ch_state_e        st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             tc;

    assign tc      = (cnt_q == TC);
    assign cnt_inc = tc ? '0 : cnt_q + CNT_W'(1);

    always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      if (!locked_q) begin
        st_d  = CH_OFF;
        cnt_d = '0;
      end else begin
        unique case (st_q)
          CH_OFF: begin
            if (bus.ch_en[g]) begin
              st_d  = CH_RUN;
              cnt_d = '0;
            end
          end
          CH_RUN: begin
            cnt_d = cnt_inc;
            if (!bus.ch_en[g]) st_d = CH_DRAIN;
          end
          CH_DRAIN: begin
            // Re-request resumes without touching the phase; otherwise finish the period.
            if (bus.ch_en[g]) begin
              st_d  = CH_RUN;
              cnt_d = cnt_inc;
            end else if (tc) begin
              st_d  = CH_OFF;
              cnt_d = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
          default: begin
            st_d  = CH_OFF;
            cnt_d = '0;
          end
        endcase
`ifdef PHY_CLK_PHASE_ALIGN_EN
        if (bus.sync_i && (st_q != CH_OFF) && (st_d != CH_OFF)) cnt_d = '0;
`endif
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        st_q  <= CH_OFF;
        cnt_q <= '0;
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
      end
    end

    // Gated by locked_q so a lock drop silences outputs before the state clears.
    assign active_w[g]  = locked_q && (st_q != CH_OFF);
    assign ce_w[g]      = active_w[g] && tc;
    assign clk_div_w[g] = active_w[g] && (cnt_q < HALF);
  end

  assign bus.ce      = ce_w;
  assign bus.clk_div = clk_div_w;
  assign bus.active  = active_w;

endmodule

// File: tb/tb_phy_clk_enable_gen.sv
// Directed bench for phy_clk_enable_gen: lock qualification, run/drain, lock loss, reset, sync.
`timescale 1ns/1ps
module tb_phy_clk_enable_gen;
  localparam int unsigned NCH = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp  = 0;
  int   n_fail = 0;

  phy_clk_enable_gen_if #(.NUM_CH(NCH)) bus ();

  phy_clk_enable_gen #(
    .NUM_CH(NCH), .CNT_W(8), .DIV0(5), .DIV1(10), .DIV2(50), .DIVN(1),
    .LOCK_CYCLES(1024), .LOCK_W(11)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int unsigned n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_ce(input int unsigned c0, c1, c2, input logic [3:0] on);
    return {on[3], on[2] && (c2 == 49), on[1] && (c1 == 9), on[0] && (c0 == 4)};
  endfunction

  function automatic logic [3:0] exp_div(input int unsigned c0, c1, c2, input logic [3:0] on);
    return {1'b0, on[2] && (c2 < 25), on[1] && (c1 < 5), on[0] && (c0 < 2)};
  endfunction

  initial begin
    logic [3:0] on;
    int unsigned t, c0, c1, c2;

    rst = 1'b1;
    bus.pll_locked = 1'b0;
    bus.ch_en      = '0;
    bus.sync_i     = 1'b0;
    tick(3);
    chk("rst_ce", bus.ce, 4'h0);
    chk("rst_clk_div", bus.clk_div, 4'h0);
    chk("rst_active", bus.active, 4'h0);
    chk("rst_locked", bus.locked, 1'b0);

    rst = 1'b0;
    bus.ch_en = 4'hF;
    bus.pll_locked = 1'b1;
    tick(1025);
    chk("lock_early", bus.locked, 1'b0);
    chk("lock_early_active", bus.active, 4'h0);
    tick();
    chk("lock_on", bus.locked, 1'b1);
    chk("lock_on_active", bus.active, 4'h0);
    tick();

    for (int unsigned k = 0; k < 80; k++) begin
      on = {k <= 71, k < 50, 1'b1, 1'b1};
      chk("run_ce", bus.ce, exp_ce(k % 5, k % 10, k % 50, on));
      chk("run_clk_div", bus.clk_div, exp_div(k % 5, k % 10, k % 50, on));
      chk("run_active", bus.active, on);
      if (k == 10) bus.ch_en = 4'b1011;
      if (k == 62) bus.ch_en = 4'b1001;
      if (k == 64) bus.ch_en = 4'b1011;
      if (k == 70) bus.ch_en = 4'b0011;
      tick();
    end

    bus.ch_en = 4'hF;
    tick();
    chk("restart_active", bus.active, 4'hF);
    bus.pll_locked = 1'b0;
    tick();
    bus.pll_locked = 1'b1;
    tick();
    chk("loss_lock_hold", bus.locked, 1'b1);
    chk("loss_active_hold", bus.active, 4'hF);
    tick();
    chk("loss_ce", bus.ce, 4'h0);
    chk("loss_clk_div", bus.clk_div, 4'h0);
    chk("loss_active", bus.active, 4'h0);
    chk("loss_locked", bus.locked, 1'b0);
    tick(1023);
    chk("relock_early", bus.locked, 1'b0);
    chk("relock_early_active", bus.active, 4'h0);
    tick();
    chk("relock_on", bus.locked, 1'b1);
    tick();
    chk("relock_active", bus.active, 4'hF);
    chk("relock_ce", bus.ce, 4'b1000);
    chk("relock_clk_div", bus.clk_div, 4'b0111);
    tick(3);
    chk("cnt3_ce", bus.ce, 4'b1000);
    chk("cnt3_clk_div", bus.clk_div, 4'b0110);

    rst = 1'b1;
    bus.ch_en = 4'b0001;
    tick();
    chk("srst_ce", bus.ce, 4'h0);
    chk("srst_clk_div", bus.clk_div, 4'h0);
    chk("srst_active", bus.active, 4'h0);
    chk("srst_locked", bus.locked, 1'b0);
    tick(2);
    rst = 1'b0;
    tick(1025);
    chk("requal_early", bus.locked, 1'b0);
    tick();
    chk("requal_on", bus.locked, 1'b1);

    tick();
    tick(3);
    bus.ch_en = 4'b0011;
    tick();
    tick(3);
    bus.ch_en = 4'b0111;
    tick();
    tick(12);
    bus.sync_i = 1'b1;
    tick();
    bus.sync_i = 1'b0;
    for (int unsigned s = 0; s <= 100; s++) begin
      t = 21 + s;
`ifdef PHY_CLK_PHASE_ALIGN_EN
      c0 = s % 5;
      c1 = s % 10;
      c2 = s % 50;
`else
      c0 = t % 5;
      c1 = (t + 6) % 10;
      c2 = (t + 42) % 50;
`endif
      chk("sync_ce", bus.ce, exp_ce(c0, c1, c2, 4'b0111));
      chk("sync_clk_div", bus.clk_div, exp_div(c0, c1, c2, 4'b0111));
      chk("sync_active", bus.active, 4'b0111);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
